sram_fifo_ctrl: RTL and testbench
=================================

# sram_fifo_ctrl

Sequencing controller that turns the team's dual-port synchronous SRAM macro into a circular FIFO. Owns the write and read pointers, the occupancy count and the full/empty flags, and drives the SRAM's chip-enable, write-enable, read-enable and address ports. Producers and consumers see a push/pop interface. The SRAM's one-cycle registered read latency is exposed as `rd_valid`. It sits between the datapath stages that buffer words through the SRAM and the SRAM instance itself.

## Interface
Parameters:
- `ADDR_WIDTH`, 4: SRAM address width. `DEPTH` must equal 2**`ADDR_WIDTH`.
- `DATA_WIDTH`, 32: word width, matching the SRAM.
- `DEPTH`, 16: number of entries.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous clear of FIFO state.
- `push` in 1: write request.
- `push_data` in `DATA_WIDTH`: word to write.
- `pop` in 1: read request.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `count` out `ADDR_WIDTH+1`: occupancy.
- `rd_valid` out 1: `rd_data` is valid this cycle.
- `rd_data` out `DATA_WIDTH`: popped word; passthrough of `sram_dout`.
- `overflow` out 1: sticky, set when a push is rejected.
- `underflow` out 1: sticky, set when a pop is rejected.
- `sram_chip_en` out 1: SRAM chip enable.
- `sram_wen` out 1: SRAM write enable.
- `sram_ren` out 1: SRAM read enable.
- `sram_waddr` out `ADDR_WIDTH`: SRAM write address.
- `sram_raddr` out `ADDR_WIDTH`: SRAM read address.
- `sram_din` out `DATA_WIDTH`: SRAM write data.
- `sram_dout` in `DATA_WIDTH`: SRAM read data (registered inside the SRAM).

## Operation
- Pointers `wptr` and `rptr` are `ADDR_WIDTH+1` bits. The low bits drive the SRAM addresses. The MSB is a wrap bit. Both pointers wrap modulo 2·`DEPTH`.
- `push_acc = push & ~full & ~flush`.
  - On `push_acc`: `sram_wen=1`, `sram_waddr=wptr[ADDR_WIDTH-1:0]`, `sram_din=push_data` (combinational), then `wptr` increments.
- `pop_acc = pop & ~empty & ~flush`.
  - On `pop_acc`: `sram_ren=1`, `sram_raddr=rptr[ADDR_WIDTH-1:0]`, then `rptr` increments.
- `sram_chip_en = sram_wen | sram_ren`.
- `full` and `empty` are evaluated on the pre-edge state, so pushes and pops in the same cycle do not see each other.
  - Push and pop while full: pop accepted, push rejected, `overflow` set, count becomes `DEPTH-1`.
  - Push and pop while empty: push accepted, pop rejected, `underflow` set, count becomes 1.
  - Push and pop otherwise: both accepted, count unchanged. Read and write addresses never collide because `count ≥ 1`.
- `count` is updated as +1 on push only, −1 on pop only, unchanged on both or neither.
- `flush` has priority over `push` and `pop`. It zeroes both pointers and `count`, and clears `overflow`/`underflow`. No SRAM enables are asserted during flush.
- A pop accepted in the cycle before `flush` or `rst` deassertion still yields `rd_valid` on the next cycle. SRAM contents are never cleared.
- Reset values: `wptr=0`, `rptr=0`, `count=0`, `empty=1`, `full=0`, `rd_valid=0`, `overflow=0`, `underflow=0`. All SRAM enables are 0 while `rst` is high.
- Asserting `rst` mid-operation aborts any in-flight read: `rd_valid` drops immediately.

## Timing
- Write latency: a push at edge N is readable by a pop issued in cycle N+1.
- Read latency is 1 cycle: pop accepted in cycle N gives `rd_valid=1` in cycle N+1, with `rd_data=sram_dout` holding the addressed word.
- `rd_valid` is a register equal to the previous cycle's `pop_acc`.
- Throughput: one push and one pop per cycle, sustained.
- `full`, `empty` and `count` are registered outputs. SRAM control outputs are combinational from `push`/`pop` and registered state.

## Structure
- Shared package holds:
  - `ADDR_WIDTH`/`DATA_WIDTH`/`DEPTH` defaults shared with the SRAM.
  - A `ptr_t` typedef of width `ADDR_WIDTH+1`.
- One natural sub-module, `fifo_wrap_ptr`: a pointer register with increment enable, sync clear and async reset. Instantiate it twice, once for `wptr` and once for `rptr`.
- The SRAM is instantiated outside this block, in the parent.

## Test plan
- After reset, push 3 words (0xA, 0xB, 0xC), then pop 3 → `rd_valid` one cycle after each pop, with `rd_data` = 0xA, 0xB, 0xC in order; `count` ends at 0 and `empty` = 1.
- Push 16 words → `full`=1 and `count`=16. A 17th push → `sram_wen`=0, `overflow`=1, contents unchanged.
- At `full`, push and pop in the same cycle → pop returns the oldest word, push is dropped, `count`=15.
- At `empty`, push and pop in the same cycle → `underflow`=1, `rd_valid`=0 on the next cycle, `count`=1.
- Run 40 push/pop pairs back-to-back from `count`=5 → pointers wrap past 15/31, data order is preserved, `count` stays at 5.
- Pop in cycle N, then `flush` in cycle N+1 with a simultaneous push → `rd_valid` in N+1 with the popped data; the push is ignored; `count`=0 and `empty`=1 afterwards. Repeat the sequence with `rst` pulsed instead of `flush` → `rd_valid` drops immediately.

Source files
------------

// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared SRAM geometry and pointer type for the SRAM-backed FIFO controller.
package sram_fifo_ctrl_pkg;
   localparam int SRAM_ADDR_WIDTH = 4;
   localparam int SRAM_DATA_WIDTH = 32;
   localparam int SRAM_DEPTH      = 1 << SRAM_ADDR_WIDTH;
   localparam int RD_LAT          = 1;

   // Extra MSB is the wrap bit that tells full from empty when addresses match.
   typedef logic [SRAM_ADDR_WIDTH:0] ptr_t;
endpackage

// File: rtl/sram_fifo_ctrl_wrap_ptr.sv
// Wrapping pointer register: increment enable, synchronous clear, async reset.
module fifo_wrap_ptr
   import sram_fifo_ctrl_pkg::*;
#(
   parameter int W = $bits(ptr_t)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] ptr
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      ptr <= '0;
      else if (clr) ptr <= '0;
      else if (inc) ptr <= ptr + W'(1);
   end
endmodule

// File: rtl/sram_fifo_ctrl.sv
// Circular FIFO sequencer around a dual-port SRAM with one-cycle registered read.
module sram_fifo_ctrl
   import sram_fifo_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
   parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
   parameter int DEPTH      = SRAM_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  sram_chip_en,
   output logic                  sram_wen,
   output logic                  sram_ren,
   output logic [ADDR_WIDTH-1:0] sram_waddr,
   output logic [ADDR_WIDTH-1:0] sram_raddr,
   output logic [DATA_WIDTH-1:0] sram_din,
   input  logic [DATA_WIDTH-1:0] sram_dout
);
   if (DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
      $error("sram_fifo_ctrl: DEPTH must equal 2**ADDR_WIDTH");
   end

   logic [ADDR_WIDTH:0] wptr, rptr;
   logic                push_acc, pop_acc;
   logic [RD_LAT:0]     vld_pipe;
   logic [RD_LAT-1:0]   vld_q;

   // rst gates acceptance so no SRAM enable can fire while in reset.
   assign push_acc = push & ~full  & ~flush & ~rst;
   assign pop_acc  = pop  & ~empty & ~flush & ~rst;

   fifo_wrap_ptr #(.W(ADDR_WIDTH+1)) u_wptr (
      .clk (clk), .rst (rst), .clr (flush), .inc (push_acc), .ptr (wptr)
   );
   fifo_wrap_ptr #(.W(ADDR_WIDTH+1)) u_rptr (
      .clk (clk), .rst (rst), .clr (flush), .inc (pop_acc), .ptr (rptr)
   );

   assign sram_wen     = push_acc;
   assign sram_ren     = pop_acc;
   assign sram_chip_en = sram_wen | sram_ren;
   assign sram_waddr   = wptr[ADDR_WIDTH-1:0];
   assign sram_raddr   = rptr[ADDR_WIDTH-1:0];
   assign sram_din     = push_data;

   assign full  = (count == (ADDR_WIDTH+1)'(DEPTH));
   assign empty = (count == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         case ({push_acc, pop_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push & full)  overflow  <= 1'b1;
         if (pop  & empty) underflow <= 1'b1;
      end
   end

   // Valid follows the SRAM's read latency; flush does not cancel an issued read.
   assign vld_pipe = {vld_q, pop_acc};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_q <= '0;
      else     vld_q <= vld_pipe[RD_LAT-1:0];
   end

   assign rd_valid = vld_pipe[RD_LAT];
   assign rd_data  = sram_dout;
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench: queue-based reference model, SRAM behavioural model, vectors + random.
module tb_sram_fifo_ctrl;
   import sram_fifo_ctrl_pkg::*;

   localparam int AW = SRAM_ADDR_WIDTH;
   localparam int DW = SRAM_DATA_WIDTH;
   localparam int DP = SRAM_DEPTH;

   logic          clk, rst, flush, push, pop;
   logic [DW-1:0] push_data, rd_data, sram_din, sram_dout;
   logic          full, empty, rd_valid, overflow, underflow;
   logic [AW:0]   count;
   logic          sram_chip_en, sram_wen, sram_ren;
   logic [AW-1:0] sram_waddr, sram_raddr;

   sram_fifo_ctrl dut (
      .clk(clk), .rst(rst), .flush(flush), .push(push), .push_data(push_data), .pop(pop),
      .full(full), .empty(empty), .count(count), .rd_valid(rd_valid), .rd_data(rd_data),
      .overflow(overflow), .underflow(underflow), .sram_chip_en(sram_chip_en),
      .sram_wen(sram_wen), .sram_ren(sram_ren), .sram_waddr(sram_waddr),
      .sram_raddr(sram_raddr), .sram_din(sram_din), .sram_dout(sram_dout)
   );

   // Dual-port SRAM with registered read port.
   logic [DW-1:0] mem [DP];
   always @(posedge clk) begin
      if (sram_chip_en && sram_wen) mem[sram_waddr] <= sram_din;
      if (sram_chip_en && sram_ren) sram_dout <= mem[sram_raddr];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: the FIFO is a queue; pointers are running totals mod 2*DEPTH.
   logic [DW-1:0] q [$];
   int            m_wp, m_rp;
   bit            m_ov, m_un, m_rv;
   logic [DW-1:0] m_rd;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_wp = 0; m_rp = 0; m_ov = 0; m_un = 0; m_rv = 0;
   endtask

   // Drive one cycle from a negedge, check combinational SRAM controls, then registered state.
   task automatic cycle(input bit p, input bit pp, input bit f, input logic [DW-1:0] d);
      bit wen_e, ren_e;
      push = p; pop = pp; flush = f; push_data = d;
      #1;
      wen_e = p  && (q.size() < DP) && !f;
      ren_e = pp && (q.size() > 0)  && !f;
      chk("sram_wen", sram_wen, wen_e);
      chk("sram_ren", sram_ren, ren_e);
      chk("sram_chip_en", sram_chip_en, wen_e || ren_e);
      if (wen_e) begin
         chk("sram_waddr", sram_waddr, m_wp % DP);
         chk("sram_din", sram_din, d);
      end
      if (ren_e) chk("sram_raddr", sram_raddr, m_rp % DP);
      @(posedge clk);
      if (f) begin
         model_reset();
      end else begin
         m_rv = ren_e;
         if (ren_e) begin m_rd = q.pop_front(); m_rp = (m_rp + 1) % (2*DP); end
         if (wen_e) begin q.push_back(d);       m_wp = (m_wp + 1) % (2*DP); end
         if (p  && !wen_e) m_ov = 1;
         if (pp && !ren_e) m_un = 1;
      end
      @(negedge clk);
      chk("count", count, q.size());
      chk("full", full, q.size() == DP);
      chk("empty", empty, q.size() == 0);
      chk("overflow", overflow, m_ov);
      chk("underflow", underflow, m_un);
      chk("rd_valid", rd_valid, m_rv);
      if (m_rv) chk("rd_data", rd_data, m_rd);
   endtask

   typedef struct {
      bit            push;
      bit            pop;
      logic [DW-1:0] data;
      int            cnt;
      bit            rv;
      logic [DW-1:0] rdata;
   } vec_t;
   vec_t vecs [7];

   initial begin
      vecs[0] = '{1, 0, 32'hA, 1, 0, 0};
      vecs[1] = '{1, 0, 32'hB, 2, 0, 0};
      vecs[2] = '{1, 0, 32'hC, 3, 0, 0};
      vecs[3] = '{0, 1, 32'h0, 2, 1, 32'hA};
      vecs[4] = '{0, 1, 32'h0, 1, 1, 32'hB};
      vecs[5] = '{0, 1, 32'h0, 0, 1, 32'hC};
      vecs[6] = '{0, 0, 32'h0, 0, 0, 0};

      // Reset, with push/pop asserted to prove the SRAM stays idle.
      rst = 1; flush = 0; push = 1; pop = 1; push_data = 32'h55;
      model_reset();
      #1;
      chk("rst_wen", sram_wen, 0);
      chk("rst_chip_en", sram_chip_en, 0);
      @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_underflow", underflow, 0);
      @(negedge clk);
      chk("rst_hold_count", count, 0);
      rst = 0; push = 0; pop = 0;

      foreach (vecs[i]) begin
         cycle(vecs[i].push, vecs[i].pop, 0, vecs[i].data);
         chk("vec_count", count, vecs[i].cnt);
         chk("vec_rd_valid", rd_valid, vecs[i].rv);
         if (vecs[i].rv) chk("vec_rd_data", rd_data, vecs[i].rdata);
      end

      // Fill, then overflow.
      for (int i = 0; i < DP; i++) cycle(1, 0, 0, $urandom);
      chk("fill_full", full, 1);
      chk("fill_count", count, DP);
      cycle(1, 0, 0, 32'hDEAD_BEEF);
      chk("ovf_flag", overflow, 1);
      chk("ovf_count", count, DP);

      // Push+pop while full: pop wins, push dropped.
      cycle(1, 1, 0, 32'hBAD0_0001);
      chk("full_pp_count", count, DP-1);

      while (q.size() > 0) cycle(0, 1, 0, 0);
      // Push+pop while empty: push wins, pop rejected.
      cycle(1, 1, 0, 32'h1234_5678);
      chk("empty_pp_underflow", underflow, 1);
      chk("empty_pp_rd_valid", rd_valid, 0);
      chk("empty_pp_count", count, 1);

      // Sustained push/pop from count 5 across pointer wrap.
      for (int i = 0; i < 4; i++) cycle(1, 0, 0, $urandom);
      for (int i = 0; i < 40; i++) cycle(1, 1, 0, $urandom);
      chk("stream_count", count, 5);

      // Pop then flush+push: the issued read still completes.
      cycle(0, 1, 0, 0);
      chk("pre_flush_rd_valid", rd_valid, 1);
      cycle(1, 0, 1, 32'hF00D);
      chk("flush_count", count, 0);
      chk("flush_empty", empty, 1);
      chk("flush_overflow", overflow, 0);

      // Pop then async reset: valid drops at once.
      cycle(1, 0, 0, 32'h77);
      cycle(1, 0, 0, 32'h88);
      cycle(0, 1, 0, 0);
      chk("pre_rst_rd_valid", rd_valid, 1);
      rst = 1; push = 1; pop = 0;
      #1;
      chk("rst_pulse_rd_valid", rd_valid, 0);
      chk("rst_pulse_count", count, 0);
      chk("rst_pulse_wen", sram_wen, 0);
      @(negedge clk);
      rst = 0; push = 0;
      model_reset();

      // Randomized traffic with occasional flush.
      for (int i = 0; i < 500; i++)
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 24) == 0), $urandom);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
